// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the two byte-stream request channels, the TX FIFO write port and
// the arbiter status/control signals into one interface.
//   master : arbiter side (drives READY, W_INC, WR_DATA, GNT, ERR_TIMEOUT)
//   slave  : environment side (requesters, FIFO, error clear)
// Signals:
//   REQ0_VALID/DATA/LAST, REQ0_READY  requester 0 channel
//   REQ1_VALID/DATA/LAST, REQ1_READY  requester 1 channel
//   FULL, W_INC, WR_DATA              FIFO write port
//   GNT, ERR_TIMEOUT, ERR_CLR         owner indication and watchdog flag
interface fifo_wr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              REQ0_VALID;
  logic [DATA_W-1:0] REQ0_DATA;
  logic              REQ0_LAST;
  logic              REQ0_READY;
  logic              REQ1_VALID;
  logic [DATA_W-1:0] REQ1_DATA;
  logic              REQ1_LAST;
  logic              REQ1_READY;
  logic              FULL;
  logic              W_INC;
  logic [DATA_W-1:0] WR_DATA;
  logic [1:0]        GNT;
  logic              ERR_TIMEOUT;
  logic              ERR_CLR;

  modport master (
    input  REQ0_VALID, REQ0_DATA, REQ0_LAST,
    input  REQ1_VALID, REQ1_DATA, REQ1_LAST,
    input  FULL, ERR_CLR,
    output REQ0_READY, REQ1_READY,
    output W_INC, WR_DATA, GNT, ERR_TIMEOUT
  );

  modport slave (
    output REQ0_VALID, REQ0_DATA, REQ0_LAST,
    output REQ1_VALID, REQ1_DATA, REQ1_LAST,
    output FULL, ERR_CLR,
    input  REQ0_READY, REQ1_READY,
    input  W_INC, WR_DATA, GNT, ERR_TIMEOUT
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Frame-atomic round-robin arbiter sharing one TX FIFO write port between two
// byte-stream requesters. The owner keeps the port until its LAST byte is
// written; a stall watchdog releases an owner that stops supplying bytes.
// Ports:
//   CLK    system clock
//   RST_n  asynchronous active-low reset
//   bus    fifo_wr_arbiter_if.master (request channels, FIFO write port,
//          GNT, ERR_TIMEOUT, ERR_CLR)
module fifo_wr_arbiter #(
  parameter int DATA_W      = 8,
  parameter int TO_W        = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               CLK,
  input logic               RST_n,
  fifo_wr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;
  logic              timeout;

  logic              own_valid;
  logic [DATA_W-1:0] own_data;
  logic              own_last;

  // Mux of the current owner's channel.
  assign own_valid = owner_q ? bus.REQ1_VALID : bus.REQ0_VALID;
  assign own_data  = owner_q ? bus.REQ1_DATA  : bus.REQ0_DATA;
  assign own_last  = owner_q ? bus.REQ1_LAST  : bus.REQ0_LAST;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    stall_cnt_d    = stall_cnt_q;
    timeout        = 1'b0;
    bus.REQ0_READY = 1'b0;
    bus.REQ1_READY = 1'b0;
    bus.W_INC      = 1'b0;
    bus.WR_DATA    = '0;
    bus.GNT        = 2'b00;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (bus.REQ0_VALID || bus.REQ1_VALID) begin
          state_d = GRANT;
          if (bus.REQ0_VALID && bus.REQ1_VALID) owner_d = rr_ptr_q;
          else                                  owner_d = bus.REQ1_VALID;
        end
      end
      GRANT: begin
        bus.GNT        = owner_q ? 2'b10 : 2'b01;
        bus.REQ0_READY = !owner_q && !bus.FULL;
        bus.REQ1_READY =  owner_q && !bus.FULL;
        // FULL gates the strobe combinationally so no write lands on a full FIFO.
        bus.W_INC      = own_valid && !bus.FULL;
        bus.WR_DATA    = (own_valid && !bus.FULL) ? own_data : '0;
        if (own_valid) begin
          // A FULL-stalled byte still counts as activity for the watchdog.
          stall_cnt_d = '0;
          if (!bus.FULL && own_last) begin
            state_d  = IDLE;
            rr_ptr_d = ~owner_q;
          end
        end else if (stall_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          timeout  = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over a coincident clear.
    if (timeout)          err_d = 1'b1;
    else if (bus.ERR_CLR) err_d = 1'b0;
    else                  err_d = err_q;
  end

  assign bus.ERR_TIMEOUT = err_q;

endmodule
